// File: rtl/pe_array_drain.sv
// Drain stage for the systolic PE array: snapshot the result plane, ack the array, stream elements row-major.
// Optional running checksum on sum_out when PE_DRAIN_SUM_EN is defined (tied to zero otherwise).
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | waiting for a start pulse
// WAIT_RDY  | start seen, waiting for array_ready
// CAPTURE   | latch s_out_flat into shadow, array_ack high
// STREAM    | present shadow[index] with out_valid, advance on beat
// DONE      | one-cycle done pulse, back to IDLE

module pe_array_drain #(
   parameter int  ARRAY_SIZE_1D    = 2,
   parameter int  OUTPUT_PRECISION = 32,
   localparam int RW = (ARRAY_SIZE_1D > 1) ? $clog2(ARRAY_SIZE_1D) : 1
) (
   input  logic                                                       CLK,
   input  logic                                                       RST,
   input  logic                                                       start,
   input  logic                                                       array_ready,
   input  logic [ARRAY_SIZE_1D*ARRAY_SIZE_1D*OUTPUT_PRECISION-1:0]    s_out_flat,
   output logic                                                       array_ack,
   output logic [OUTPUT_PRECISION-1:0]                                out_data,
   output logic [RW-1:0]                                              out_row,
   output logic [RW-1:0]                                              out_col,
   output logic                                                       out_valid,
   input  logic                                                       out_ready,
   output logic                                                       busy,
   output logic                                                       done,
   output logic [OUTPUT_PRECISION-1:0]                                sum_out
);

   localparam int N  = ARRAY_SIZE_1D;
   localparam int OP = OUTPUT_PRECISION;
   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_CAPTURE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [RW-1:0]   row_q, row_d;
   logic [RW-1:0]   col_q, col_d;
   logic [OP-1:0]   shadow_q [NE];
   logic            beat;
   logic            last;

   assign beat = (state_q == S_STREAM) && out_ready;
   assign last = (idx_q == IW'(NE - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start)       state_d = S_WAIT_RDY;
         S_WAIT_RDY: if (array_ready) state_d = S_CAPTURE;
         S_CAPTURE:                   state_d = S_STREAM;
         S_STREAM:   if (beat && last) state_d = S_DONE;
         S_DONE:                      state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      array_ack = (state_q == S_CAPTURE);
      out_valid = (state_q == S_STREAM);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      out_data  = '0;
      out_row   = '0;
      out_col   = '0;
      if (state_q == S_STREAM) begin
         out_data = shadow_q[idx_q];
         out_row  = row_q;
         out_col  = col_q;
      end
   end

   // Index holds on the final beat; it is re-zeroed on the next capture, so it never wraps mid-pass.
   always_comb begin
      idx_d = idx_q;
      row_d = row_q;
      col_d = col_q;
      if (state_q == S_CAPTURE) begin
         idx_d = '0;
         row_d = '0;
         col_d = '0;
      end else if (beat && !last) begin
         idx_d = idx_q + IW'(1);
         if (col_q == RW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + RW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         idx_q <= '0;
         row_q <= '0;
         col_q <= '0;
         for (int i = 0; i < NE; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         idx_q <= idx_d;
         row_q <= row_d;
         col_q <= col_d;
         if (state_q == S_CAPTURE) begin
            for (int i = 0; i < NE; i++) begin
               shadow_q[i] <= s_out_flat[i*OP +: OP];
            end
         end
      end
   end

`ifdef PE_DRAIN_SUM_EN
   logic [OP-1:0] sum_q, sum_d;

   // Wrapping add; the value persists through DONE until the next capture.
   always_comb begin
      sum_d = sum_q;
      if (state_q == S_CAPTURE) begin
         sum_d = '0;
      end else if (beat) begin
         sum_d = sum_q + out_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_out = sum_q;
`else
   assign sum_out = '0;
`endif

endmodule

// File: tb/tb_pe_array_drain.sv
// Directed bench for pe_array_drain (N=2, OP=32): table of stream passes plus hand-written corner sequences.
// Expected checksum follows PE_DRAIN_SUM_EN when the bench is built with it.

module tb_pe_array_drain;

   localparam int N  = 2;
   localparam int OP = 32;

`ifdef PE_DRAIN_SUM_EN
   localparam bit SUM_EN = 1'b1;
`else
   localparam bit SUM_EN = 1'b0;
`endif

   logic           CLK;
   logic           RST;
   logic           start;
   logic           array_ready;
   logic [127:0]   s_out_flat;
   logic           array_ack;
   logic [31:0]    out_data;
   logic [0:0]     out_row;
   logic [0:0]     out_col;
   logic           out_valid;
   logic           out_ready;
   logic           busy;
   logic           done;
   logic [31:0]    sum_out;

   int checks = 0;
   int errors = 0;

   pe_array_drain #(.ARRAY_SIZE_1D(N), .OUTPUT_PRECISION(OP)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .array_ready (array_ready),
      .s_out_flat  (s_out_flat),
      .array_ack   (array_ack),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done),
      .sum_out     (sum_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [127:0] plane;
      logic [15:0]  rpat;
      logic         corrupt;
      logic [31:0]  sum;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One full pass: start with array_ready high, then stream under the given out_ready pattern.
   task automatic run_pass(input vec_t v);
      logic [31:0] e;
      logic [31:0] exp_sum;
      int k;
      int cyc;
      exp_sum = SUM_EN ? v.sum : 32'd0;
      @(negedge CLK);
      s_out_flat  = v.plane;
      array_ready = 1'b1;
      start       = 1'b1;
      out_ready   = 1'b0;
      @(negedge CLK);
      start = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_ack", array_ack, 0);
      @(negedge CLK);
      chk("cap_ack", array_ack, 1);
      chk("cap_valid", out_valid, 0);
      k   = 0;
      cyc = 0;
      while (k < 4 && cyc < 100) begin
         @(negedge CLK);
         if (v.corrupt && cyc == 0) s_out_flat = '1;
         e = v.plane[k*32 +: 32];
         chk("valid", out_valid, 1);
         chk("data", out_data, e);
         chk("row", out_row, k / 2);
         chk("col", out_col, k % 2);
         chk("ack_low", array_ack, 0);
         out_ready = v.rpat[cyc % 16];
         if (out_ready) k++;
         cyc++;
      end
      if (k < 4) chk("stream_timeout", k, 4);
      @(negedge CLK);
      out_ready = 1'b0;
      chk("done", done, 1);
      chk("done_valid", out_valid, 0);
      chk("sum_at_done", sum_out, exp_sum);
      @(negedge CLK);
      chk("done_low", done, 0);
      chk("idle_busy", busy, 0);
      chk("sum_hold", sum_out, exp_sum);
   endtask

   initial begin
      vecs[0] = '{128'h00000004_00000003_00000002_00000001, 16'hFFFF, 1'b0, 32'd10};
      vecs[1] = '{128'h00000004_00000003_00000002_00000001, 16'h9999, 1'b1, 32'd10};
      vecs[2] = '{128'h00000000_00000005_00000001_FFFFFFFF, 16'hFFFF, 1'b0, 32'd5};
      vecs[3] = '{128'h80000000_00000000_12345678_DEADBEEF, 16'h5555, 1'b0, 32'h70E21567};

      RST         = 1'b1;
      start       = 1'b0;
      array_ready = 1'b0;
      s_out_flat  = '0;
      out_ready   = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack", array_ack, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sum", sum_out, 0);
      RST = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_pass(vecs[i]);
      end

      // Wait on array, a start while busy, and a start landing in the DONE cycle.
      @(negedge CLK);
      s_out_flat  = 128'h00000008_00000007_00000006_00000005;
      array_ready = 1'b0;
      start       = 1'b1;
      out_ready   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("wr_ack", array_ack, 0);
         chk("wr_valid", out_valid, 0);
         chk("wr_busy", busy, 1);
         start = (i == 2);
         @(negedge CLK);
      end
      start       = 1'b0;
      array_ready = 1'b1;
      @(negedge CLK);
      chk("wr_ack_rise", array_ack, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("wr_ack_once", array_ack, 0);
         chk("wr_data", out_data, 32'd5 + 32'(k));
      end
      @(negedge CLK);
      chk("wr_done", done, 1);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("start_in_done_ignored", busy, 0);
      @(negedge CLK);
      chk("still_idle", busy, 0);

      // Reset mid-stream after two beats.
      s_out_flat = 128'h00000004_00000003_00000002_00000001;
      start      = 1'b1;
      out_ready  = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("ms_data0", out_data, 1);
      @(negedge CLK);
      chk("ms_data1", out_data, 2);
      @(negedge CLK);
      chk("ms_data2", out_data, 3);
      RST = 1'b1;
      @(negedge CLK);
      RST       = 1'b0;
      out_ready = 1'b0;
      chk("ms_valid", out_valid, 0);
      chk("ms_busy", busy, 0);
      chk("ms_done", done, 0);
      chk("ms_data", out_data, 0);
      chk("ms_sum", sum_out, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("ms_no_done", done, 0);
         chk("ms_idle", busy, 0);
      end
      run_pass(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
